inst_rr_scheduler: RTL and testbench
====================================

Name: inst_rr_scheduler

Overview:
- Round-robin scheduler that shares one downstream transfer channel between NUM_REQ child-instance requesters (inst_0..inst_4 in a five-child root module).
- Grants one requester at a time and holds the grant for a burst.
- Burst ends on the requester's last beat or after MAX_BURST beats.
- Muxes the granted requester's valid/data/last onto the shared channel and routes ready back to it.

Parameters:
NUM_REQ, 5, number of requesters (2..8)
DATA_W, 8, payload width per requester
MAX_BURST, 4, max beats per grant before forced rotation (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_W  packed payloads, requester i at [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  per-requester last-beat flag
req_ready  output  NUM_REQ  per-requester beat accepted
out_valid  output  1  shared channel valid
out_data  output  DATA_W  shared channel payload
out_last  output  1  burst end (req_last or MAX_BURST reached)
out_src  output  SRC_W  index of granted requester, SRC_W=$clog2(NUM_REQ)
out_ready  input  1  downstream accept
busy  output  1  grant held (state XFER)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, gnt=0, beat_cnt=0.
  - All outputs 0: req_ready=0, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0.
- Beat definition: out_valid&&out_ready.
- FSM IDLE:
  - If any req_valid: gnt<=first i scanning ptr, ptr+1, … wrapping NUM_REQ-1→0; beat_cnt<=0; go to XFER.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle: a request in cycle N can produce its first beat no earlier than cycle N+1.
- FSM XFER:
  - out_valid=req_valid[gnt], out_data=req_data[gnt], out_src=gnt.
  - req_ready[gnt]=out_ready; all other req_ready=0. Combinational pass-through, zero added latency.
  - On each beat: beat_cnt+=1.
  - Burst end: beat with req_last[gnt]=1 or beat_cnt==MAX_BURST-1. out_last=1 on that beat.
  - On burst end: ptr<=(gnt==NUM_REQ-1)?0:gnt+1; go to IDLE.
  - Granted requester dropping valid mid-burst: grant is held, no rotation (no timeout).
- Outside XFER: out_valid=0, out_data=0, out_last=0, req_ready=0.
- Handshake: once a requester asserts req_valid, it holds data/last stable until req_ready.
- Boundary cases:
  - gnt=NUM_REQ-1 wraps ptr to 0.
  - Single active requester regains the grant after a 1-cycle IDLE gap.
  - MAX_BURST=1 makes every beat a burst end.
  - Simultaneous req_last and MAX_BURST limit count as a single burst end.
  - Reset mid-burst aborts immediately; the partial burst is not resumed.

Optional Feature:
- Macro: INST_RR_SCHED_PRIO0_EN.
- Defined: in IDLE, req_valid[0]=1 wins regardless of ptr. After a priority-0 burst, ptr is unchanged, so requester 0 does not disturb the others' rotation.
  - Bursts already in XFER are never preempted.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package inst_sched_pkg:
  - state enum sched_state_e {IDLE, XFER}.
  - Default NUM_REQ/DATA_W/MAX_BURST constants.
  - function next_idx(cur, n) for wrap increment.
- Sub-module rr_pick: combinational "first set bit at or after ptr, wrapping" on a NUM_REQ vector.
  - Outputs found and idx.
  - Reused in IDLE arbitration.

Test Plan:
- Reset: assert rst_n=0 mid-XFER with gnt=3 → all outputs 0 within the same cycle; after release, ptr=0 and first grant goes to lowest valid index.
- All 5 requesters valid, 1-beat bursts (req_last=1), out_ready=1 → out_src sequence 0,1,2,3,4,0 with one IDLE cycle between beats.
- Requester 2 alone streams 10 beats with req_last only on beat 10, MAX_BURST=4 → bursts of 4,4,2; out_last on beats 4, 8, 10; out_src=2 throughout.
- Backpressure: out_ready toggles 1,0,0,1 during a grant to requester 1 → beat_cnt advances only on ready cycles; req_ready[1] mirrors out_ready; other req_ready stay 0.
- Wrap: ptr=4, requesters 0 and 4 valid → grant 4 first, then 0.
- With INST_RR_SCHED_PRIO0_EN: ptr=2, requesters 0 and 3 valid → grant 0, then 3; ptr=4 after.

Source files
------------

// File: rtl/inst_sched_pkg.sv
// Shared types and helpers for the instance round-robin scheduler.
// Provides the FSM state encoding, default sizing constants and a
// wrap-around index increment used for the rotation pointer.
package inst_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_e;

    localparam int DEF_NUM_REQ   = 5;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Increment an index modulo n (n-1 wraps to 0).
    function automatic int next_idx(input int cur, input int n);
        return (cur == n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set bit of vec at or
// after position ptr, wrapping from N-1 back to 0.
module rr_pick #(
    parameter  int N = 5,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan offsets from farthest to nearest so the last hit written is the
    // closest set bit at or after ptr.
    always_comb begin
        int          j;
        logic [W-1:0] jw;
        // NOTE: every output of a combinational block gets a default before
        // any conditional update, otherwise a latch is inferred.
        found = |vec;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jw = W'(j);
            if (vec[jw]) begin
                idx = jw;
            end
        end
    end

endmodule

// File: rtl/inst_rr_scheduler.sv
// Round-robin scheduler sharing one transfer channel between NUM_REQ
// requesters. A grant is held for a burst that ends on the requester's last
// beat or after MAX_BURST beats; the granted requester's valid/data/last are
// muxed onto the channel and out_ready is routed back as its req_ready.
// Optional: define INST_RR_SCHED_PRIO0_EN to let requester 0 win every
// arbitration without disturbing the rotation pointer of the others.
module inst_rr_scheduler
    import inst_sched_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int CNT_W = 8;

    sched_state_e     state;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] gnt;
    logic [CNT_W-1:0] beat_cnt;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              pick_found;
    logic [SRC_W-1:0]  pick_idx;
    logic [SRC_W-1:0]  win_idx;
    logic              xfer;
    logic              sel_valid;
    logic              sel_last;
    logic              cnt_max;
    logic              beat;
    logic              burst_end;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .vec   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef INST_RR_SCHED_PRIO0_EN
    assign win_idx = req_valid[0] ? '0 : pick_idx;
`else
    assign win_idx = pick_idx;
`endif

    assign xfer      = (state == XFER);
    assign sel_valid = req_valid[gnt];
    assign sel_last  = req_last[gnt];
    assign cnt_max   = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign beat      = xfer && sel_valid && out_ready;
    assign burst_end = beat && (sel_last || cnt_max);

    // Channel mux: pass the granted requester through with no added latency.
    always_comb begin
        req_ready      = '0;
        out_valid      = xfer && sel_valid;
        out_data       = xfer ? data_arr[gnt] : '0;
        out_last       = xfer && sel_valid && (sel_last || cnt_max);
        out_src        = xfer ? gnt : '0;
        busy           = xfer;
        if (xfer) begin
            req_ready[gnt] = out_ready;
        end
    end

    // Arbitration FSM: pick a winner in IDLE, count beats and rotate in XFER.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt      <= win_idx;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (burst_end) begin
`ifdef INST_RR_SCHED_PRIO0_EN
                        if (gnt != '0) begin
                            ptr <= SRC_W'(next_idx(int'(gnt), NUM_REQ));
                        end
`else
                        ptr <= SRC_W'(next_idx(int'(gnt), NUM_REQ));
`endif
                        state <= IDLE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Self-checking bench for inst_rr_scheduler (default parameters 5/8/4).
// Requester sources are small beat FIFOs; expected channel beats are queued
// by each test in the order the arbitration rules predict and popped by a
// monitor on every observed beat.
module tb_inst_rr_scheduler;

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [39:0] req_data;
    logic [4:0]  req_last;
    logic [4:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_src;
    logic        out_ready;
    logic        busy;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    beat_t exp_q[$];
    int    beat_cyc[$];

    logic [7:0] sd [5][32];
    logic       sl [5][32];
    int         hd [5];
    int         tl [5];

    inst_rr_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] dval(input int s, input int k);
        return 8'(s * 32 + k);
    endfunction

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            if (hd[i] < tl[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = sd[i][hd[i]];
                req_last[i]         = sl[i][hd[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic load(input int s, input int k, input logic l);
        sd[s][tl[s]] = dval(s, k);
        sl[s][tl[s]] = l;
        tl[s]++;
        drive();
    endtask

    task automatic expect_beat(input int s, input int k, input logic l);
        exp_q.push_back('{src: 3'(s), data: dval(s, k), last: l});
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 5; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive();
    endtask

    // Source model: retire the head beat of every requester that handshook.
    initial begin
        logic [4:0] fire;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 5; i++) begin
                if (fire[i] && hd[i] < tl[i]) hd[i]++;
            end
            drive();
        end
    end

    // Scoreboard monitor: compare each channel beat with the queued prediction.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got src=%0d data=%h last=%b, required no beat",
                             out_src, out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_src, out_data, out_last} !== {e.src, e.data, e.last}) begin
                        n_err++;
                        $display("FAIL beat: got src=%0d data=%h last=%b, required src=%0d data=%h last=%b",
                                 out_src, out_data, out_last, e.src, e.data, e.last);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clear_sources();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        beat_cyc.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy: got busy=%b, required 1", name, busy);
        end
    endtask

    task automatic check_gap(input string name, input int k, input int want);
        n_vec++;
        if (beat_cyc.size() <= k) begin
            n_err++;
            $display("FAIL %s_gap%0d: got %0d beats recorded, required more than %0d",
                     name, k, beat_cyc.size(), k);
        end else if (beat_cyc[k] - beat_cyc[k-1] !== want) begin
            n_err++;
            $display("FAIL %s_gap%0d: got %0d cycles, required %0d",
                     name, k, beat_cyc[k] - beat_cyc[k-1], want);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clear_sources();
        #1;
        n_vec++;
        if ({req_ready, out_valid, out_data, out_last, out_src, busy} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {req_ready, out_valid, out_data, out_last, out_src, busy});
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        // One burst from requester 1 moves the pointer away from 0.
        expect_beat(1, 0, 1'b1);
        load(1, 0, 1'b1);
        wait_drain("reset_pre");
        // Requester 3 takes the grant and is held by backpressure.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        load(3, 0, 1'b0);
        load(3, 1, 1'b1);
        wait_busy("reset_gnt3");
        @(negedge clk);
        n_vec++;
        if ({busy, out_valid, out_src, req_ready} !== {1'b1, 1'b1, 3'd3, 5'd0}) begin
            n_err++;
            $display("FAIL reset_hold: got busy=%b valid=%b src=%0d ready=%b, required 1 1 3 00000",
                     busy, out_valid, out_src, req_ready);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, out_valid, out_data, out_last, out_src, busy} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_midburst: got %h, required 0",
                     {req_ready, out_valid, out_data, out_last, out_src, busy});
        end
        clear_sources();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // Pointer restarts at 0: requester 1 wins over requester 2.
        expect_beat(1, 0, 1'b1);
        expect_beat(2, 0, 1'b1);
        load(2, 0, 1'b1);
        load(1, 0, 1'b1);
        wait_drain("reset_post");
    endtask

    task automatic test_round_robin();
        do_reset();
        out_ready = 1'b1;
`ifdef INST_RR_SCHED_PRIO0_EN
        expect_beat(0, 0, 1'b1);
        expect_beat(0, 1, 1'b1);
        for (int i = 1; i < 5; i++) expect_beat(i, 0, 1'b1);
`else
        for (int i = 0; i < 5; i++) expect_beat(i, 0, 1'b1);
        expect_beat(0, 1, 1'b1);
`endif
        for (int i = 0; i < 5; i++) load(i, 0, 1'b1);
        load(0, 1, 1'b1);
        wait_drain("rr");
        for (int k = 1; k < 6; k++) check_gap("rr", k, 2);
    endtask

    task automatic test_max_burst();
        int gaps[10] = '{0, 1, 1, 1, 2, 1, 1, 1, 2, 1};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_beat(2, k, (k == 3 || k == 7 || k == 9));
        end
        for (int k = 0; k < 10; k++) load(2, k, (k == 9));
        wait_drain("maxb");
        for (int k = 1; k < 10; k++) check_gap("maxb", k, gaps[k]);
    endtask

    task automatic test_last_at_max();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) expect_beat(4, k, (k >= 3));
        for (int k = 0; k < 5; k++) load(4, k, (k >= 3));
        wait_drain("lastmax");
        check_gap("lastmax", 3, 1);
        check_gap("lastmax", 4, 2);
    endtask

    task automatic test_backpressure();
        logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 4; k++) expect_beat(1, k, (k == 3));
        expect_beat(3, 0, 1'b1);
        for (int k = 0; k < 4; k++) load(1, k, 1'b0);
        load(3, 0, 1'b1);
        wait_busy("bp");
        for (int p = 0; p < 6; p++) begin
            @(posedge clk);
            #2;
            out_ready = pat[p];
            @(negedge clk);
            n_vec++;
            if ({req_ready, out_src} !== {(pat[p] ? 5'b00010 : 5'b00000), 3'd1}) begin
                n_err++;
                $display("FAIL bp_ready%0d: got ready=%b src=%0d, required ready=%b src=1",
                         p, req_ready, out_src, (pat[p] ? 5'b00010 : 5'b00000));
            end
        end
        wait_drain("bp");
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        expect_beat(3, 0, 1'b1);
        load(3, 0, 1'b1);
        wait_drain("wrap_pre");
        @(posedge clk);
        #2;
`ifdef INST_RR_SCHED_PRIO0_EN
        expect_beat(0, 0, 1'b1);
        expect_beat(4, 0, 1'b1);
`else
        expect_beat(4, 0, 1'b1);
        expect_beat(0, 0, 1'b1);
`endif
        load(0, 0, 1'b1);
        load(4, 0, 1'b1);
        wait_drain("wrap");
    endtask

    task automatic test_prio0();
        do_reset();
        out_ready = 1'b1;
        expect_beat(1, 0, 1'b1);
        load(1, 0, 1'b1);
        wait_drain("prio_pre");
        @(posedge clk);
        #2;
`ifdef INST_RR_SCHED_PRIO0_EN
        expect_beat(0, 0, 1'b1);
        expect_beat(3, 0, 1'b1);
`else
        expect_beat(3, 0, 1'b1);
        expect_beat(0, 0, 1'b1);
`endif
        load(0, 0, 1'b1);
        load(3, 0, 1'b1);
        wait_drain("prio_mid");
        @(posedge clk);
        #2;
`ifdef INST_RR_SCHED_PRIO0_EN
        expect_beat(4, 1, 1'b1);
        expect_beat(2, 1, 1'b1);
`else
        expect_beat(2, 1, 1'b1);
        expect_beat(4, 1, 1'b1);
`endif
        load(2, 1, 1'b1);
        load(4, 1, 1'b1);
        wait_drain("prio_post");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_max_burst();
        test_last_at_max();
        test_backpressure();
        test_wrap();
        test_prio0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
